// File: rtl/wide_inv_pkg.sv
// Shared types and the per-beat word transform for the wide_inv_pipe block.
// The transform works on a fixed maximum width; callers pass their real width.
package wide_inv_pkg;

  typedef enum logic [1:0] {
    MODE_INV  = 2'd0,
    MODE_PASS = 2'd1,
    MODE_MASK = 2'd2,
    MODE_REV  = 2'd3
  } mode_e;

  localparam int WIP_MAX_W = 1024;

  // Reversal is done over the full container and shifted down so that the
  // caller's bit 0 receives its bit width-1; width is a constant at every call.
  function automatic logic [WIP_MAX_W-1:0] wip_transform(
    input mode_e                mode,
    input logic [WIP_MAX_W-1:0] data,
    input logic [WIP_MAX_W-1:0] mask,
    input int                   width
  );
    logic [WIP_MAX_W-1:0] rev;
    for (int i = 0; i < WIP_MAX_W; i++) begin
      rev[i] = data[WIP_MAX_W-1-i];
    end
    case (mode)
      MODE_INV:  wip_transform = ~data;
      MODE_PASS: wip_transform = data;
      MODE_MASK: wip_transform = data ^ mask;
      default:   wip_transform = rev >> (WIP_MAX_W - width);
    endcase
  endfunction

endpackage

// File: rtl/wide_inv_stage.sv
// One elastic pipeline slot: holds a valid flag and a DW-bit payload.
// The slot reloads whenever it is empty or its content is taken downstream.
module wide_inv_stage #(
  parameter int DW = 32
) (
  input  logic          clock,
  input  logic          rst,
  input  logic          up_valid,
  input  logic [DW-1:0] up_data,
  input  logic          down_ready,
  output logic          valid,
  output logic [DW-1:0] data
);

  logic load;

  assign load = ~valid | down_ready;

  // Payload only moves with a real beat so d_out keeps its last value on bubbles.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= up_valid;
      if (up_valid) begin
        data <= up_data;
      end
    end
  end

endmodule

// File: rtl/wide_inv_pipe.sv
// Selectable bitwise transform followed by a DEPTH-stage valid/ready pipeline.
// Optional WIDE_INV_PIPE_PARITY_EN adds an even-parity bit carried with each beat.
module wide_inv_pipe
  import wide_inv_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 2,
  parameter int INIT_CYCLES = 4
) (
  input  logic             clock,
  input  logic             rst,
  output logic             rdy,
  input  logic             in_valid,
  output logic             in_ready,
  input  mode_e            in_mode,
  input  logic [WIDTH-1:0] in_mask,
  input  logic [WIDTH-1:0] d_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d_out
`ifdef WIDE_INV_PIPE_PARITY_EN
  ,
  output logic             d_par
`endif
);

  localparam int CW = $clog2(INIT_CYCLES + 1);

`ifdef WIDE_INV_PIPE_PARITY_EN
  localparam int DW = WIDTH + 1;
`else
  localparam int DW = WIDTH;
`endif

  logic [CW-1:0]    init_cnt;
  logic [WIDTH-1:0] xform;
  logic [DW-1:0]    head;
  logic [DEPTH-1:0] s_vld;
  logic [DW-1:0]    s_dat [DEPTH];
  logic [DEPTH-1:0] adv;

  // rdy rises on the edge where the count reaches INIT_CYCLES and then sticks.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      init_cnt <= '0;
      rdy      <= 1'b0;
    end else if (!rdy) begin
      init_cnt <= init_cnt + 1'b1;
      if (init_cnt == CW'(INIT_CYCLES - 1)) begin
        rdy <= 1'b1;
      end
    end
  end

  assign xform = WIDTH'(wip_transform(in_mode, WIP_MAX_W'(d_in), WIP_MAX_W'(in_mask), WIDTH));

`ifdef WIDE_INV_PIPE_PARITY_EN
  assign head = {^xform, xform};
`else
  assign head = xform;
`endif

  // adv[k]: the downstream side will take stage k's content this cycle.
  always_comb begin
    adv            = '0;
    adv[DEPTH-1]   = out_ready;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      adv[k] = ~s_vld[k+1] | adv[k+1];
    end
  end

  assign in_ready = rdy & (~s_vld[0] | adv[0]);

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic          up_valid;
    logic [DW-1:0] up_data;

    if (k == 0) begin : g_head
      assign up_valid = in_valid & rdy;
      assign up_data  = head;
    end else begin : g_link
      assign up_valid = s_vld[k-1];
      assign up_data  = s_dat[k-1];
    end

    wide_inv_stage #(
      .DW(DW)
    ) u_stage (
      .clock      (clock),
      .rst        (rst),
      .up_valid   (up_valid),
      .up_data    (up_data),
      .down_ready (adv[k]),
      .valid      (s_vld[k]),
      .data       (s_dat[k])
    );
  end

  assign out_valid = s_vld[DEPTH-1];
  assign d_out     = s_dat[DEPTH-1][WIDTH-1:0];

`ifdef WIDE_INV_PIPE_PARITY_EN
  assign d_par = s_dat[DEPTH-1][WIDTH];
`endif

endmodule

// File: tb/tb_wide_inv_pipe.sv
// Scoreboard bench for wide_inv_pipe: accepted beats queue their expected word,
// an independent monitor pops and compares every delivered beat.
module tb_wide_inv_pipe;
  import wide_inv_pkg::*;

  localparam int WIDTH       = 32;
  localparam int DEPTH       = 2;
  localparam int INIT_CYCLES = 4;

  logic        clock     = 1'b0;
  logic        rst       = 1'b0;
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b1;
  mode_e       in_mode   = MODE_INV;
  logic [31:0] in_mask   = '0;
  logic [31:0] d_in      = '0;
  logic        rdy;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] d_out;
`ifdef WIDE_INV_PIPE_PARITY_EN
  logic        d_par;
`endif

  int          n_checks = 0;
  int          n_err    = 0;
  logic [31:0] exp_q[$];

  always #5 clock = ~clock;

  wide_inv_pipe #(
    .WIDTH       (WIDTH),
    .DEPTH       (DEPTH),
    .INIT_CYCLES (INIT_CYCLES)
  ) dut (
    .clock     (clock),
    .rst       (rst),
    .rdy       (rdy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_mask   (in_mask),
    .d_in      (d_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d_out     (d_out)
`ifdef WIDE_INV_PIPE_PARITY_EN
    ,
    .d_par     (d_par)
`endif
  );

  function automatic logic [31:0] ref_xform(input mode_e m, input logic [31:0] d, input logic [31:0] k);
    logic [31:0] r;
    r = '0;
    case (m)
      MODE_INV:  r = ~d;
      MODE_PASS: r = d;
      MODE_MASK: r = d ^ k;
      default: begin
        for (int i = 0; i < 32; i++) r[i] = d[31-i];
      end
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Scoreboard push: every handshake seen just before the rising edge.
  initial begin
    forever begin
      @(negedge clock);
      #4;
      if (rst && in_valid && in_ready) exp_q.push_back(ref_xform(in_mode, d_in, in_mask));
    end
  end

  // Monitor: every delivered beat must match the oldest outstanding expectation.
  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(negedge clock);
      #4;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL spurious_out: got %0h required no beat", d_out);
        end else begin
          e = exp_q.pop_front();
          chk("d_out", {32'd0, d_out}, {32'd0, e});
`ifdef WIDE_INV_PIPE_PARITY_EN
          chk("d_par", {63'd0, d_par}, {63'd0, ^e});
`endif
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic send(input mode_e m, input logic [31:0] d, input logic [31:0] k, output int waits);
    waits = 0;
    @(negedge clock);
    in_valid = 1'b1;
    in_mode  = m;
    d_in     = d;
    in_mask  = k;
    #4;
    while (!in_ready) begin
      if (waits >= 100) begin
        chk("send_timeout", 64'(waits), 64'd0);
        in_valid = 1'b0;
        return;
      end
      waits++;
      @(negedge clock);
      #4;
    end
  endtask

  task automatic idle();
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
      @(negedge clock);
      #4;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic send_rand(output int waits);
    send(mode_e'($urandom_range(0, 3)), $urandom, $urandom, waits);
  endtask

  initial begin : main
    int          w;
    int          tot;
    int          acc;
    int          bad;
    logic        have;
    logic [31:0] held;

    // Reset state, with a beat already offered before initialisation completes.
    in_valid = 1'b1;
    in_mode  = MODE_INV;
    d_in     = 32'hFFFF_FFFF;
    repeat (3) @(negedge clock);
    #4;
    chk("rst_rdy",       {63'd0, rdy},       64'd0);
    chk("rst_in_ready",  {63'd0, in_ready},  64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_d_out",     {32'd0, d_out},     64'd0);
`ifdef WIDE_INV_PIPE_PARITY_EN
    chk("rst_d_par",     {63'd0, d_par},     64'd0);
`endif

    @(negedge clock);
    rst = 1'b1;
    #4;
    for (int i = 0; i < INIT_CYCLES; i++) begin
      if (i != 0) begin
        @(negedge clock);
        #4;
      end
      chk("init_rdy",       {63'd0, rdy},       64'd0);
      chk("init_in_ready",  {63'd0, in_ready},  64'd0);
      chk("init_out_valid", {63'd0, out_valid}, 64'd0);
    end
    @(negedge clock);
    #4;
    chk("init_rdy_up",      {63'd0, rdy},      64'd1);
    chk("init_in_ready_up", {63'd0, in_ready}, 64'd1);

    // Directed vectors; the first beat (0xFFFFFFFF INV) is taken right now.
    send(MODE_INV,  32'hFFFF_0000, 32'h0,          w);
    send(MODE_INV,  32'h5555_5555, 32'h0,          w);
    send(MODE_MASK, 32'h1111_1111, 32'h3333_3333, w);
    send(MODE_REV,  32'h0000_0001, 32'h0,          w);
    send(MODE_PASS, 32'h8888_8888, 32'h0,          w);
    send(MODE_PASS, 32'h0000_0001, 32'h0,          w);
    send(MODE_PASS, 32'h0000_0003, 32'h0,          w);
    send(MODE_REV,  32'hC000_0005, 32'h0,          w);
    idle();
    drain();

    // Latency on an empty pipe.
    send(MODE_INV, 32'h1234_5678, 32'h0, w);
    idle();
    #4;
    chk("lat_early", {63'd0, out_valid}, 64'd0);
    @(negedge clock);
    #4;
    chk("lat_on_time", {63'd0, out_valid}, 64'd1);
    chk("lat_data",    {32'd0, d_out},     {32'd0, 32'hEDCB_A987});
    drain();

    // Sustained random stream with out_ready held high: no stalls allowed.
    tot = 0;
    for (int i = 0; i < 24; i++) begin
      send_rand(w);
      tot += w;
    end
    idle();
    chk("no_bubble", 64'(tot), 64'd0);
    drain();

    // Backpressure for 5 cycles while the source keeps offering beats.
    @(negedge clock);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = mode_e'($urandom_range(0, 3));
    d_in      = $urandom;
    in_mask   = $urandom;
    acc  = 0;
    bad  = 0;
    have = 1'b0;
    held = '0;
    for (int c = 0; c < 5; c++) begin
      #4;
      if (in_ready) acc++;
      if (out_valid) begin
        if (have && d_out != held) bad++;
        if (!have) begin
          held = d_out;
          have = 1'b1;
        end
      end
      @(negedge clock);
      if (in_ready) begin
        in_mode = mode_e'($urandom_range(0, 3));
        d_in    = $urandom;
        in_mask = $urandom;
      end
    end
    #4;
    chk("bp_accepted",  64'(acc),            64'(DEPTH));
    chk("bp_in_ready",  {63'd0, in_ready},   64'd0);
    chk("bp_out_valid", {63'd0, out_valid},  64'd1);
    chk("bp_stable",    64'(bad),            64'd0);
    chk("bp_held",      {32'd0, d_out},      {32'd0, held});
    @(negedge clock);
    out_ready = 1'b1;
    #4;
    chk("bp_release_ready", {63'd0, in_ready}, 64'd1);
    for (int i = 0; i < 6; i++) send_rand(w);
    idle();
    drain();

    // Random backpressure mixed with a random stream.
    fork
      begin
        for (int i = 0; i < 40; i++) send_rand(w);
        idle();
      end
      begin
        for (int i = 0; i < 120; i++) begin
          @(negedge clock);
          out_ready = ($urandom_range(0, 2) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two beats in flight.
    @(negedge clock);
    out_ready = 1'b0;
    send_rand(w);
    send_rand(w);
    idle();
    #4;
    chk("mid_full", {63'd0, out_valid}, 64'd1);
    @(negedge clock);
    rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_rdy",       {63'd0, rdy},       64'd0);
    chk("mid_rst_in_ready",  {63'd0, in_ready},  64'd0);
    exp_q.delete();
    out_ready = 1'b1;
    repeat (2) @(negedge clock);
    rst = 1'b1;
    for (int i = 0; i < 20 && !rdy; i++) begin
      @(negedge clock);
      #4;
    end
    chk("reinit_rdy",       {63'd0, rdy},       64'd1);
    chk("reinit_out_valid", {63'd0, out_valid}, 64'd0);
    for (int i = 0; i < 5; i++) send_rand(w);
    idle();
    drain();
    repeat (4) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
